// File: rtl/mem_arbiter.sv
// Two-port arbiter for a single-port DRAM: port 0 issues single-word accesses,
// port 1 issues auto-incrementing bursts that yield to port 0 after HOLD_MAX beats.
module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 1,
    parameter int HOLD_MAX = 8
) (
    input  logic              Clk1,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              We0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] WData0,
    output logic              Gnt0,
    output logic              Done0,
    output logic [DATA_W-1:0] RData0,
    input  logic              Req1,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [7:0]        Len1,
    input  logic [DATA_W-1:0] WData1,
    output logic              WAck1,
    output logic              RValid1,
    output logic [DATA_W-1:0] RData1,
    output logic              Gnt1,
    output logic              Done1,
    output logic [ADDR_W-1:0] Addr,
    output logic              RD,
    output logic              WR,
    output logic [DATA_W-1:0] DataOut,
    input  logic [DATA_W-1:0] DataIn
);

    typedef enum logic [2:0] {
        IDLE, P0_ACC, P0_WAIT, P1_ACC, P1_WAIT, P1_END
    } state_t;

    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

    state_t              state, state_nxt;
    logic                grant0, grant1;
    logic                beat_end;
    logic                last_gnt;
    logic                paused;
    logic [HOLD_W-1:0]   hold;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                done0;
    logic [DATA_W-1:0]   rdata0;
    logic                p0_we;
    logic [ADDR_W-1:0]   p0_addr;
    logic [DATA_W-1:0]   p0_wdata;
    logic                p1_we;
    logic [ADDR_W-1:0]   cur_addr;
    logic [7:0]          remaining;

    // Port 0 keeps Req0 high through its Done0 cycle; masking it there avoids a spurious re-grant.
    logic req0_eff;
    logic wait_last;
    logic yield;
    assign req0_eff  = Req0 && !done0;
    assign wait_last = (wait_cnt == WAIT_LAST);
    assign yield     = Req0 && (hold >= HOLD_LAST);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge Clk1) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        beat_end  = 1'b0;
        case (state)
            IDLE: begin
                if (!Reset) begin
                    if (paused) begin
                        if (req0_eff) grant0 = 1'b1;
                        else          state_nxt = P1_ACC;
                    end else if (req0_eff && Req1) begin
                        grant0 = last_gnt;
                        grant1 = !last_gnt;
                    end else begin
                        grant0 = req0_eff;
                        grant1 = Req1;
                    end
                    if (grant0)      state_nxt = P0_ACC;
                    else if (grant1) state_nxt = (Len1 == 8'd0) ? P1_END : P1_ACC;
                end
            end
            P0_ACC:  state_nxt = p0_we ? IDLE : P0_WAIT;
            P0_WAIT: if (wait_last) state_nxt = IDLE;
            P1_ACC: begin
                if (p1_we) beat_end  = 1'b1;
                else       state_nxt = P1_WAIT;
            end
            P1_WAIT: if (wait_last) beat_end = 1'b1;
            P1_END:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (beat_end) begin
            if (remaining == 8'd1) state_nxt = P1_END;
            else if (yield)        state_nxt = IDLE;
            else                   state_nxt = P1_ACC;
        end
    end

    always_comb begin
        Gnt0    = grant0;
        Gnt1    = grant1;
        Done0   = done0;
        RData0  = rdata0;
        Done1   = (state == P1_END) && !Reset;
        Addr    = '0;
        RD      = 1'b0;
        WR      = 1'b0;
        DataOut = '0;
        WAck1   = 1'b0;
        RValid1 = 1'b0;
        RData1  = '0;
        case (state)
            P0_ACC: begin
                Addr = p0_addr;
                RD   = !p0_we;
                WR   = p0_we;
                if (p0_we) DataOut = p0_wdata;
            end
            P1_ACC: begin
                Addr  = cur_addr;
                RD    = !p1_we;
                WR    = p1_we;
                WAck1 = p1_we;
                if (p1_we) DataOut = WData1;
            end
            P1_WAIT: begin
                if (wait_last) begin
                    RValid1 = 1'b1;
                    RData1  = DataIn;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            last_gnt  <= 1'b1;
            paused    <= 1'b0;
            hold      <= '0;
            wait_cnt  <= '0;
            done0     <= 1'b0;
            rdata0    <= '0;
            p0_we     <= 1'b0;
            p0_addr   <= '0;
            p0_wdata  <= '0;
            p1_we     <= 1'b0;
            cur_addr  <= '0;
            remaining <= '0;
        end else begin
            done0 <= 1'b0;
            if (grant0) begin
                p0_we    <= We0;
                p0_addr  <= Addr0;
                p0_wdata <= WData0;
            end
            if (grant1) begin
                p1_we     <= We1;
                cur_addr  <= Addr1;
                remaining <= Len1;
                hold      <= '0;
            end
            if (state == IDLE && paused && !req0_eff) paused <= 1'b0;
            if (state == P0_ACC) begin
                last_gnt <= 1'b0;
                done0    <= p0_we;
            end
            if (state == P0_WAIT || state == P1_WAIT)
                wait_cnt <= wait_last ? '0 : wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;
            if (state == P0_WAIT && wait_last) begin
                rdata0 <= DataIn;
                done0  <= 1'b1;
            end
            if (beat_end) begin
                cur_addr  <= cur_addr + ADDR_W'(1);
                remaining <= remaining - 8'd1;
                if (!Req0) begin
                    hold <= '0;
                end else if (yield) begin
                    hold <= '0;
                    // A final beat completes the burst instead of pausing it.
                    if (remaining != 8'd1) paused <= 1'b1;
                end else begin
                    hold <= hold + HOLD_W'(1);
                end
            end
            if (state == P1_END) last_gnt <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural DRAM (RD_LAT = 1):
// single accesses, alternation, wrapping write burst, yielding read burst, empty burst, mid-burst reset.
module tb_mem_arbiter;

    logic        Clk1 = 1'b0;
    logic        Reset;
    logic        Req0, We0, Req1, We1;
    logic [15:0] Addr0, WData0, Addr1, WData1;
    logic [7:0]  Len1;
    logic        Gnt0, Done0, Gnt1, Done1, WAck1, RValid1, RD, WR;
    logic [15:0] RData0, RData1, Addr, DataOut, DataIn;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int strobe_err = 0;

    logic [15:0] mem [logic [15:0]];
    logic [15:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
    int          wr_cyc_q[$];

    mem_arbiter dut (
        .Clk1(Clk1), .Reset(Reset),
        .Req0(Req0), .We0(We0), .Addr0(Addr0), .WData0(WData0),
        .Gnt0(Gnt0), .Done0(Done0), .RData0(RData0),
        .Req1(Req1), .We1(We1), .Addr1(Addr1), .Len1(Len1), .WData1(WData1),
        .WAck1(WAck1), .RValid1(RValid1), .RData1(RData1), .Gnt1(Gnt1), .Done1(Done1),
        .Addr(Addr), .RD(RD), .WR(WR), .DataOut(DataOut), .DataIn(DataIn)
    );

    always #5 Clk1 = ~Clk1;

    function automatic logic [15:0] pat(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    // DRAM model: one-cycle read latency; unwritten locations return pat(addr).
    always @(posedge Clk1) begin
        cyc <= cyc + 1;
        if (RD && WR) strobe_err <= strobe_err + 1;
        if (WR) begin
            mem[Addr] = DataOut;
            wr_addr_q.push_back(Addr);
            wr_data_q.push_back(DataOut);
            wr_cyc_q.push_back(cyc);
        end
        if (RD) begin
            DataIn <= mem.exists(Addr) ? mem[Addr] : pat(Addr);
            rd_addr_q.push_back(Addr);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk1);
        #1;
    endtask

    task automatic idle_inputs();
        Req0 = 0; We0 = 0; Addr0 = '0; WData0 = '0;
        Req1 = 0; We1 = 0; Addr1 = '0; Len1 = '0; WData1 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1;
        tick();
        tick();
        Reset = 0;
    endtask

    task automatic test_reset();
        Reset = 1;
        idle_inputs();
        Req0 = 1;
        Req1 = 1;
        tick();
        tick();
        #1;
        checks++;
        if ({Gnt0, Gnt1, Done0, Done1, WAck1, RValid1, RD, WR, Addr, DataOut, RData0, RData1} !== '0)
            $display("FAIL reset_outputs: got G0=%b G1=%b D0=%b D1=%b RD=%b WR=%b Addr=%h DO=%h R0=%h R1=%h expected all zero",
                     Gnt0, Gnt1, Done0, Done1, RD, WR, Addr, DataOut, RData0, RData1);
        else passed++;
        Reset = 0;
        idle_inputs();
    endtask

    task automatic test_p0_write_read();
        do_reset();
        Req0 = 1; We0 = 1; Addr0 = 16'h0010; WData0 = 16'hBEEF;
        #1;
        checks++;
        if (Gnt0 !== 1'b1) $display("FAIL p0_wr_gnt: got %b expected 1", Gnt0);
        else passed++;
        tick(); #1;
        checks++;
        if ({WR, RD, Addr, DataOut, Done0} !== {1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0})
            $display("FAIL p0_wr_strobe: got WR=%b RD=%b Addr=%h DO=%h D0=%b expected 1 0 0010 beef 0",
                     WR, RD, Addr, DataOut, Done0);
        else passed++;
        tick(); #1;
        checks++;
        if ({Done0, WR, RD} !== 3'b100) $display("FAIL p0_wr_done: got D0=%b WR=%b RD=%b expected 1 0 0", Done0, WR, RD);
        else passed++;
        Req0 = 0;
        tick();
        Req0 = 1; We0 = 0; Addr0 = 16'h0010; WData0 = 16'h0000;
        #1;
        checks++;
        if (Gnt0 !== 1'b1) $display("FAIL p0_rd_gnt: got %b expected 1", Gnt0);
        else passed++;
        tick(); #1;
        checks++;
        if ({RD, WR, Addr} !== {1'b1, 1'b0, 16'h0010})
            $display("FAIL p0_rd_strobe: got RD=%b WR=%b Addr=%h expected 1 0 0010", RD, WR, Addr);
        else passed++;
        tick(); #1;
        checks++;
        if ({Done0, RD, WR} !== 3'b000) $display("FAIL p0_rd_wait: got D0=%b RD=%b WR=%b expected 0 0 0", Done0, RD, WR);
        else passed++;
        tick(); #1;
        checks++;
        if ({Done0, RData0} !== {1'b1, 16'hBEEF})
            $display("FAIL p0_rd_done: got D0=%b RData0=%h expected 1 beef", Done0, RData0);
        else passed++;
        Req0 = 0;
    endtask

    task automatic test_alternation();
        do_reset();
        Req0 = 1; We0 = 1; Addr0 = 16'h0100; WData0 = 16'h0001;
        Req1 = 1; We1 = 1; Addr1 = 16'h0200; Len1 = 8'd1; WData1 = 16'h0007;
        #1;
        checks++;
        if ({Gnt0, Gnt1} !== 2'b10) $display("FAIL alt_first_tie: got G0G1=%b%b expected 10", Gnt0, Gnt1);
        else passed++;
        Req1 = 0;
        tick(); #1;
        tick(); #1;
        checks++;
        if ({Done0, Gnt0, Gnt1} !== 3'b100) $display("FAIL alt_done0: got D0=%b G0=%b G1=%b expected 1 0 0", Done0, Gnt0, Gnt1);
        else passed++;
        Req0 = 0;
        tick();
        Req0 = 1; Req1 = 1;
        #1;
        checks++;
        if ({Gnt0, Gnt1} !== 2'b01) $display("FAIL alt_second_tie: got G0G1=%b%b expected 01", Gnt0, Gnt1);
        else passed++;
        Req0 = 0;
        tick(); #1;
        tick(); #1;
        checks++;
        if (Done1 !== 1'b1) $display("FAIL alt_done1: got %b expected 1", Done1);
        else passed++;
        Req1 = 0;
        tick();
        Req0 = 1; Req1 = 1;
        #1;
        checks++;
        if ({Gnt0, Gnt1} !== 2'b10) $display("FAIL alt_third_tie: got G0G1=%b%b expected 10", Gnt0, Gnt1);
        else passed++;
        Req0 = 0; Req1 = 0;
    endtask

    task automatic test_burst_write_wrap();
        logic [15:0] exp_addr [4];
        int  w0, wack, done1_cyc, bad;
        bit  adv, done1_seen;
        exp_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        do_reset();
        w0 = wr_addr_q.size();
        Req1 = 1; We1 = 1; Addr1 = 16'hFFFE; Len1 = 8'd4; WData1 = 16'd1;
        #1;
        checks++;
        if (Gnt1 !== 1'b1) $display("FAIL bw_gnt: got %b expected 1", Gnt1);
        else passed++;
        adv = 0; wack = 0; done1_seen = 0; done1_cyc = 0;
        for (int i = 0; i < 20 && !done1_seen; i++) begin
            tick();
            if (adv) WData1 = WData1 + 16'd1;
            #1;
            adv = WAck1;
            if (WAck1) wack++;
            if (Done1) begin
                done1_seen = 1;
                done1_cyc  = cyc;
            end
        end
        Req1 = 0;
        checks++;
        if (!done1_seen || wack != 4) $display("FAIL bw_done_wack: got done1=%b wack=%0d expected 1 4", done1_seen, wack);
        else passed++;
        checks++;
        if (wr_addr_q.size() - w0 != 4) $display("FAIL bw_wr_count: got %0d expected 4", wr_addr_q.size() - w0);
        else passed++;
        if (wr_addr_q.size() - w0 >= 4) begin
            bad = 0;
            for (int k = 0; k < 4; k++)
                if (wr_addr_q[w0+k] !== exp_addr[k] || wr_data_q[w0+k] !== 16'(k + 1)) bad++;
            checks++;
            if (bad != 0) $display("FAIL bw_addr_data: got %0d wrong beats (first %h/%h) expected 0",
                                   bad, wr_addr_q[w0], wr_data_q[w0]);
            else passed++;
            checks++;
            if (wr_cyc_q[w0+3] - wr_cyc_q[w0] != 3 || done1_cyc != wr_cyc_q[w0+3] + 1)
                $display("FAIL bw_timing: got span=%0d done1_gap=%0d expected 3 1",
                         wr_cyc_q[w0+3] - wr_cyc_q[w0], done1_cyc - wr_cyc_q[w0+3]);
            else passed++;
        end
    endtask

    task automatic test_burst_read_yield();
        int  rv, bad, gnt0_at_rv, r0;
        bit  raised, done0_seen, done1_seen;
        logic [15:0] done0_data, exp_a;
        do_reset();
        r0 = rd_addr_q.size();
        Req1 = 1; We1 = 0; Addr1 = 16'h1000; Len1 = 8'd20;
        #1;
        checks++;
        if (Gnt1 !== 1'b1) $display("FAIL br_gnt: got %b expected 1", Gnt1);
        else passed++;
        rv = 0; bad = 0; gnt0_at_rv = -1; raised = 0; done0_seen = 0; done1_seen = 0; done0_data = '0;
        for (int i = 0; i < 300 && !done1_seen; i++) begin
            tick();
            if (rv == 2 && !raised) begin
                Req0 = 1; We0 = 0; Addr0 = 16'h0042;
                raised = 1;
            end
            #1;
            if (RValid1) begin
                if (RData1 !== pat(16'h1000 + 16'(rv))) bad++;
                rv++;
            end
            if (Gnt0) gnt0_at_rv = rv;
            if (Done0) begin
                done0_seen = 1;
                done0_data = RData0;
                Req0 = 0;
            end
            if (Done1) done1_seen = 1;
        end
        Req1 = 0; Req0 = 0;
        checks++;
        if (!done1_seen || rv != 20) $display("FAIL br_count: got done1=%b rvalid=%0d expected 1 20", done1_seen, rv);
        else passed++;
        checks++;
        if (bad != 0) $display("FAIL br_data: got %0d wrong beats expected 0", bad);
        else passed++;
        // Req0 is high from beat 2 on, so beats 2..9 fill the hold budget of 8.
        checks++;
        if (gnt0_at_rv != 10) $display("FAIL br_yield_point: got Gnt0 after %0d beats expected 10", gnt0_at_rv);
        else passed++;
        checks++;
        if (!done0_seen || done0_data !== pat(16'h0042))
            $display("FAIL br_p0_read: got done0=%b data=%h expected 1 %h", done0_seen, done0_data, pat(16'h0042));
        else passed++;
        checks++;
        if (rd_addr_q.size() - r0 != 21) $display("FAIL br_rd_count: got %0d expected 21", rd_addr_q.size() - r0);
        else passed++;
        if (rd_addr_q.size() - r0 == 21) begin
            bad = 0;
            for (int k = 0; k < 21; k++) begin
                exp_a = (k < 10) ? 16'h1000 + 16'(k) : (k == 10) ? 16'h0042 : 16'h1000 + 16'(k - 1);
                if (rd_addr_q[r0+k] !== exp_a) bad++;
            end
            checks++;
            if (bad != 0) $display("FAIL br_rd_addrs: got %0d wrong addresses (resume %h) expected 0", bad, rd_addr_q[r0+11]);
            else passed++;
        end
    endtask

    task automatic test_len_zero();
        int r0, w0;
        do_reset();
        r0 = rd_addr_q.size();
        w0 = wr_addr_q.size();
        Req1 = 1; We1 = 1; Addr1 = 16'h3000; Len1 = 8'd0;
        #1;
        checks++;
        if (Gnt1 !== 1'b1) $display("FAIL len0_gnt: got %b expected 1", Gnt1);
        else passed++;
        tick(); #1;
        checks++;
        if ({Done1, RD, WR, WAck1} !== 4'b1000) $display("FAIL len0_done: got D1=%b RD=%b WR=%b WAck1=%b expected 1 0 0 0",
                                                        Done1, RD, WR, WAck1);
        else passed++;
        Req1 = 0;
        tick();
        tick(); #1;
        checks++;
        if (rd_addr_q.size() != r0 || wr_addr_q.size() != w0)
            $display("FAIL len0_strobes: got %0d reads %0d writes expected 0 0", rd_addr_q.size() - r0, wr_addr_q.size() - w0);
        else passed++;
    endtask

    task automatic test_reset_mid_burst();
        int d1;
        do_reset();
        Req1 = 1; We1 = 0; Addr1 = 16'h2000; Len1 = 8'd5;
        #1;
        checks++;
        if (Gnt1 !== 1'b1) $display("FAIL rmb_gnt: got %b expected 1", Gnt1);
        else passed++;
        tick();
        tick();
        Reset = 1;
        tick(); #1;
        checks++;
        if ({Gnt0, Gnt1, Done0, Done1, WAck1, RValid1, RD, WR, Addr, DataOut, RData0, RData1} !== '0)
            $display("FAIL rmb_outputs: got G1=%b D1=%b RV=%b RD=%b WR=%b Addr=%h expected all zero",
                     Gnt1, Done1, RValid1, RD, WR, Addr);
        else passed++;
        Reset = 0;
        Req1 = 0;
        d1 = 0;
        for (int i = 0; i < 6; i++) begin
            tick(); #1;
            if (Done1) d1++;
        end
        checks++;
        if (d1 != 0) $display("FAIL rmb_no_done1: got %0d Done1 pulses expected 0", d1);
        else passed++;
        Req0 = 1; We0 = 1; Addr0 = 16'h0055; WData0 = 16'h1234;
        #1;
        checks++;
        if (Gnt0 !== 1'b1) $display("FAIL rmb_p0_gnt: got %b expected 1", Gnt0);
        else passed++;
        tick(); #1;
        tick(); #1;
        checks++;
        if (Done0 !== 1'b1) $display("FAIL rmb_p0_done: got %b expected 1", Done0);
        else passed++;
        Req0 = 0;
    endtask

    task automatic test_bus_rules();
        checks++;
        if (strobe_err != 0) $display("FAIL rd_wr_overlap: got %0d cycles with RD and WR high expected 0", strobe_err);
        else passed++;
    endtask

    initial begin
        idle_inputs();
        Reset = 1;
        test_reset();
        test_p0_write_read();
        test_alternation();
        test_burst_write_wrap();
        test_burst_read_yield();
        test_len_zero();
        test_reset_mid_burst();
        tick();
        test_bus_rules();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
